// File: rtl/lab2_pkg.sv
// Shared types and default timing constants for the lab 2 display-source controller.
package lab2_pkg;

    typedef enum logic {
        SHOW_S0 = 1'b0,
        SHOW_S1 = 1'b1
    } sel_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int DWELL_CYCLES_DEF    = 100_000_000;
    localparam int CNT_W_DEF           = 27;

endpackage

// File: rtl/lab2_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce and rising-edge pulse.
module lab2_debounce
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The level is accepted only once it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_TERM) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign btn_db = db_q;
    assign rise   = db_q & ~db_prev_q;

endmodule

// File: rtl/lab2_mux_ctrl.sv
// Select sequencer for the lab 2 display mux: debounced manual toggle plus an
// auto-alternate dwell timer, with a registered select and change pulse.
module lab2_mux_ctrl
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DWELL_CYCLES    = DWELL_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic auto_en,
    input  logic hold,
    output logic ctrl,
    output logic sel_changed
);

    localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);

    sel_state_t       state_q;
    logic [CNT_W-1:0] dwell_cnt_q;
    logic [CNT_W-1:0] dwell_cnt_d;
    logic             btn_level;
    logic             btn_rise;
    logic             press;
    logic             dwell_expire;
    logic             toggle;

    lab2_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn),
        .btn_db  (btn_level),
        .rise    (btn_rise)
    );

    assign press        = btn_rise & btn_level;
    assign dwell_expire = auto_en & ~hold & (dwell_cnt_q == DWELL_TERM);
    assign toggle       = press | dwell_expire;

    // Any toggle, manual or automatic, restarts the dwell period.
    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if (!auto_en || toggle) begin
            dwell_cnt_d = '0;
        end else if (!hold) begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= SHOW_S0;
            ctrl        <= 1'b0;
            sel_changed <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            sel_changed <= toggle;
            dwell_cnt_q <= dwell_cnt_d;
            if (toggle) begin
                case (state_q)
                    SHOW_S0: begin
                        state_q <= SHOW_S1;
                        ctrl    <= 1'b1;
                    end
                    default: begin
                        state_q <= SHOW_S0;
                        ctrl    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lab2_mux_ctrl.sv
// Directed bench for lab2_mux_ctrl with DEBOUNCE_CYCLES=4, DWELL_CYCLES=10.
module tb_lab2_mux_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic btn;
    logic auto_en;
    logic hold;
    logic ctrl;
    logic sel_changed;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lab2_mux_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DWELL_CYCLES    (10),
        .CNT_W           (27)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .auto_en     (auto_en),
        .hold        (hold),
        .ctrl        (ctrl),
        .sel_changed (sel_changed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges with no select change expected
    task automatic quiet(input int n, input logic exp_ctrl, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
            check({tag, "_pulse"}, 32'(sel_changed), 32'd0);
        end
    endtask

    // one edge on which ctrl must take exp_ctrl together with the pulse
    task automatic toggle_at(input logic exp_ctrl, input string tag);
        step();
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        check({tag, "_pulse"}, 32'(sel_changed), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        btn     = 1'b1;
        auto_en = 1'b1;
        hold    = 1'b0;

        // Reset held 3 cycles with btn and auto_en active
        quiet(3, 1'b0, "reset");
        reset_n = 1'b1;
        auto_en = 1'b0;
        $display("reset: released, btn still high, manual mode");

        // btn must pass the full debounce after reset, toggling at k+6
        quiet(6, 1'b0, "rst_db");
        toggle_at(1'b1, "press1");
        quiet(13, 1'b1, "press1_held");
        btn = 1'b0;
        quiet(10, 1'b1, "press1_release");
        $display("manual: first press toggled to s1");

        btn = 1'b1;
        quiet(6, 1'b1, "press2");
        toggle_at(1'b0, "press2");
        btn = 1'b0;
        quiet(10, 1'b0, "press2_release");
        $display("manual: second press returned to s0");

        // 3-cycle glitch
        btn = 1'b1;
        quiet(3, 1'b0, "glitch");
        btn = 1'b0;
        quiet(10, 1'b0, "glitch_after");
        $display("glitch: short pulse rejected");

        // bounce 1-0-1-0 then stable high
        btn = 1'b1; quiet(1, 1'b0, "bounce");
        btn = 1'b0; quiet(1, 1'b0, "bounce");
        btn = 1'b1; quiet(1, 1'b0, "bounce");
        btn = 1'b0; quiet(1, 1'b0, "bounce");
        btn = 1'b1;
        quiet(6, 1'b0, "bounce_settle");
        toggle_at(1'b1, "bounce_press");
        btn = 1'b0;
        quiet(10, 1'b1, "bounce_release");
        $display("bounce: single toggle after settling");

        // Reset from SHOW_S1, then auto mode from release
        reset_n = 1'b0;
        step();
        check("rst_s1_ctrl", 32'(ctrl), 32'd0);
        check("rst_s1_pulse", 32'(sel_changed), 32'd0);
        reset_n = 1'b1;
        auto_en = 1'b1;
        quiet(9, 1'b0, "auto1"); toggle_at(1'b1, "auto_t10");
        quiet(9, 1'b1, "auto2"); toggle_at(1'b0, "auto_t20");
        quiet(9, 1'b0, "auto3"); toggle_at(1'b1, "auto_t30");
        quiet(9, 1'b1, "auto4"); toggle_at(1'b0, "auto_t40");
        quiet(5, 1'b0, "auto_tail");
        $display("auto: toggles at 10/20/30/40");

        // dwell_cnt is 5; one more edge makes it 6, then freeze
        quiet(1, 1'b0, "pre_hold");
        hold = 1'b1;
        quiet(15, 1'b0, "hold");
        hold = 1'b0;
        quiet(3, 1'b0, "hold_release");
        toggle_at(1'b1, "hold_resume");
        $display("hold: timer frozen, resumed 4 cycles after release");

        // Press during hold, dwell must restart from 0
        quiet(3, 1'b1, "pre_hold_press");
        hold = 1'b1;
        btn  = 1'b1;
        quiet(6, 1'b1, "hold_press");
        toggle_at(1'b0, "hold_press");
        btn = 1'b0;
        quiet(6, 1'b0, "hold_press_after");
        hold = 1'b0;
        quiet(9, 1'b0, "dwell_restart");
        toggle_at(1'b1, "dwell_restart");
        $display("hold: press honoured and dwell cleared");

        // Collision: press toggle lands on the edge where dwell_cnt==9
        quiet(3, 1'b1, "coll_pre");
        btn = 1'b1;
        quiet(6, 1'b1, "coll_wait");
        toggle_at(1'b0, "collision");
        btn = 1'b0;
        quiet(9, 1'b0, "coll_next");
        toggle_at(1'b1, "coll_next");
        $display("collision: single toggle, next auto 10 later");

        // Reset mid-dwell in SHOW_S1
        quiet(4, 1'b1, "mid_dwell");
        reset_n = 1'b0;
        step();
        check("rst_mid_ctrl", 32'(ctrl), 32'd0);
        check("rst_mid_pulse", 32'(sel_changed), 32'd0);
        reset_n = 1'b1;
        quiet(9, 1'b0, "post_rst");
        toggle_at(1'b1, "post_rst");
        $display("reset mid-run: full period after release");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lab2_mux_ctrl.md
Name: lab2_mux_ctrl

Overview:
- Sequences the select line of the lab 2 16-bit 2:1 source mux that feeds the seven-segment display path.
- Chooses which of the two 16-bit sources is shown, either from a debounced push-button toggle or from an automatic dwell timer that alternates the sources.
- Sits between the board button/switch inputs and the mux ctrl input. Its registered ctrl output connects directly to the mux.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- DWELL_CYCLES, 100_000_000: cycles each source is shown in auto mode (1 s at 100 MHz).
- CNT_W, 27: width of the debounce and dwell counters. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, DWELL_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  synchronous reset, active-low
- btn  in  1  raw asynchronous push-button, high = pressed
- auto_en  in  1  switch, 1 = auto-alternate mode
- hold  in  1  switch, 1 = freeze the auto dwell timer
- ctrl  out  1  mux select, 0 = source s0, 1 = source s1
- sel_changed  out  1  one-cycle pulse in the same cycle ctrl takes its new value

Behaviour:
- Interface: one clock, clk. Reset reset_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: ctrl=0, sel_changed=0, state=SHOW_S0. Synchronizer flops, debounced level, edge-detect register and both counters all reset to 0.
- Reset asserted mid-operation (mid-debounce or mid-dwell) returns the block to SHOW_S0 on the next edge. Any partial count is discarded.
- Synchronizer: 2-flop chain on btn. Nothing else samples btn.
- Debounce:
  - Stable level btn_db, counter db_cnt.
  - If synced btn equals btn_db: db_cnt clears.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1 and the level still differs, btn_db takes the new level and db_cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- press: btn_db rising edge, a single-cycle internal pulse. Button release generates nothing.
- Press latency: if btn is first sampled high at edge k and held, ctrl toggles at edge k+DEBOUNCE_CYCLES+2.
- State machine (SHOW_S0, SHOW_S1):
  - ctrl is 0 in SHOW_S0 and 1 in SHOW_S1, registered with no combinational path from inputs.
  - toggle = press OR dwell_expire.
  - On toggle the state flips and sel_changed is asserted for exactly one cycle, aligned with the new ctrl value.
- Dwell counter (dwell_cnt):
  - Increments when auto_en=1 and hold=0.
  - dwell_expire = auto_en & ~hold & (dwell_cnt == DWELL_CYCLES-1).
  - Clears on any toggle.
  - Held at its current value while hold=1.
  - Clears and stays 0 while auto_en=0.
  - In steady auto mode ctrl therefore toggles every DWELL_CYCLES cycles.
- Manual press is honoured in every mode, including while hold=1. A press restarts the dwell period.
- Simultaneous press and dwell_expire in the same cycle: exactly one toggle and one sel_changed pulse; dwell_cnt clears.
- auto_en deasserted: ctrl keeps its current value; no auto toggle.
- Counters never wrap: debounce clears at its terminal count, and dwell clears on toggle.

Decomposition:
- Shared package lab2_pkg:
  - typedef enum logic {SHOW_S0, SHOW_S1} sel_state_t
  - localparam default constants DEBOUNCE_CYCLES_DEF and DWELL_CYCLES_DEF
- One sub-module, lab2_debounce (parameters DEBOUNCE_CYCLES, CNT_W):
  - Ports: clk, reset_n, btn_raw in; btn_db out; rise out (one-cycle pulse).
  - Contains the synchronizer, the debounce counter and the edge detect.
  - Reusable for later labs' buttons.
- lab2_mux_ctrl holds the FSM, the dwell counter and the output registers.

Test Plan (DEBOUNCE_CYCLES=4, DWELL_CYCLES=10):
- Reset: hold reset_n=0 for 3 cycles, with btn=1 and auto_en=1 driven during reset -> ctrl=0 and sel_changed=0 throughout and on the first cycle after release. btn must then still pass the full debounce before any toggle.
- Manual toggle: auto_en=0; btn high from edge k and held for 20 cycles -> ctrl goes 0->1 at edge k+6 with a one-cycle sel_changed. No second toggle while held or on release. A second clean press returns ctrl to 0.
- Glitch rejection: btn high for 3 cycles then low -> ctrl stays 0 and sel_changed never asserts. Bouncing 1-0-1-0 pattern followed by 4+ stable high cycles -> exactly one toggle.
- Auto alternate: auto_en=1, hold=0 for 45 cycles after reset -> ctrl toggles at cycles 10, 20, 30 and 40 after auto_en rises, with one sel_changed pulse per toggle.
- Hold: auto_en=1; assert hold at dwell_cnt=6 for 15 cycles, then release -> no toggle during hold; toggle occurs 4 cycles after release. A debounced press during hold still toggles and clears dwell_cnt.
- Collision and reset mid-run: align the press edge with dwell_cnt=9 -> a single toggle and single pulse, with the next auto toggle 10 cycles later. Then assert reset_n=0 while in SHOW_S1 mid-dwell -> ctrl=0 next edge, and auto resumes a full 10-cycle period after release.
